// File: rtl/instruction_fetch_stage.sv
// Purpose: RV32IM fetch stage; owns the PC, drives the instruction-memory read and registers {PC, instr, valid} into IF/ID.
// Latency: one cycle from read completion to IF/ID; a redirect costs one bubble with zero-wait memory.
// Backpressure: STALL freezes PC and IF/ID; IMEM_BUSYWAIT holds the address stable; FLUSH overrides STALL.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_INSTR,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_INSTR,
    output logic        IFID_VALID
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] redir, redir_nx;
    logic [31:0] ifid_pc, ifid_pc_nx;
    logic [31:0] ifid_instr, ifid_instr_nx;
    logic        ifid_valid, ifid_valid_nx;
    logic        bubble;
    logic [31:0] tgt;

    // Redirect targets are always word aligned.
    assign tgt = BRANCH_TARGET & ~32'h0000_0003;

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        redir_nx      = redir;
        ifid_pc_nx    = ifid_pc;
        ifid_instr_nx = ifid_instr;
        ifid_valid_nx = ifid_valid;
        bubble        = 1'b0;

        case (state)
            IDLE: begin
                state_nx = FETCH;
                if (FLUSH) begin
                    pc_nx  = tgt;
                    bubble = 1'b1;
                end
            end
            FETCH: begin
                if (FLUSH) begin
                    bubble = 1'b1;
                    if (!IMEM_BUSYWAIT) begin
                        pc_nx = tgt;
                    end else begin
                        // Read in flight belongs to the squashed path; park the target.
                        redir_nx = tgt;
                        state_nx = DISCARD;
                    end
                end else if (!IMEM_BUSYWAIT) begin
                    if (!STALL) begin
                        ifid_pc_nx    = pc;
                        ifid_instr_nx = IMEM_INSTR;
                        ifid_valid_nx = 1'b1;
                        pc_nx         = pc + 32'd4;
                    end
                end else if (!STALL) begin
                    bubble = 1'b1;
                end
            end
            DISCARD: begin
                if (FLUSH) begin
                    redir_nx = tgt;
                end
                if (!IMEM_BUSYWAIT) begin
                    pc_nx    = FLUSH ? tgt : redir;
                    state_nx = FETCH;
                end
                bubble = !(STALL && !FLUSH);
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (bubble) begin
            ifid_valid_nx = 1'b0;
            ifid_instr_nx = NOP_INSTR;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir      <= 32'h0;
            ifid_pc    <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            redir      <= redir_nx;
            ifid_pc    <= ifid_pc_nx;
            ifid_instr <= ifid_instr_nx;
            ifid_valid <= ifid_valid_nx;
        end
    end

    assign IMEM_ADDR  = pc;
    assign IMEM_READ  = (state != IDLE);
    assign IFID_PC    = ifid_pc;
    assign IFID_INSTR = ifid_instr;
    assign IFID_VALID = ifid_valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: reset, streaming, wait states, stall, redirects, wrap, async reset.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READ;
    logic        IMEM_BUSYWAIT;
    logic [31:0] IMEM_INSTR;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_INSTR;
    logic        IFID_VALID;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 CLK = ~CLK;

    // Memory returns a word derived from its address so every instruction is identifiable.
    assign IMEM_INSTR = IMEM_ADDR ^ KEY;

    instruction_fetch_stage #(
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(NOP)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .STALL        (STALL),
        .FLUSH        (FLUSH),
        .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_READ    (IMEM_READ),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IMEM_INSTR   (IMEM_INSTR),
        .IFID_PC      (IFID_PC),
        .IFID_INSTR   (IFID_INSTR),
        .IFID_VALID   (IFID_VALID)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // IF/ID holds a valid instruction fetched from address a.
    task automatic chk_valid(input string tag, input logic [31:0] a);
        chk({tag, "_pc"}, IFID_PC, a);
        chk({tag, "_instr"}, IFID_INSTR, a ^ KEY);
        chk({tag, "_vld"}, {31'h0, IFID_VALID}, 32'h1);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_instr"}, IFID_INSTR, NOP);
        chk({tag, "_vld"}, {31'h0, IFID_VALID}, 32'h0);
    endtask

    initial begin
        RESET_N       = 1'b0;
        STALL         = 1'b0;
        FLUSH         = 1'b0;
        BRANCH_TARGET = 32'h0;
        IMEM_BUSYWAIT = 1'b0;

        // Reset state
        #12;
        chk("rst_read", {31'h0, IMEM_READ}, 32'h0);
        chk("rst_addr", IMEM_ADDR, 32'h100);
        chk("rst_ifid_pc", IFID_PC, 32'h0);
        chk_bubble("rst");

        #5 RESET_N = 1'b1;
        #1;
        chk("idle_read", {31'h0, IMEM_READ}, 32'h0);
        step();
        chk("first_read", {31'h0, IMEM_READ}, 32'h1);
        chk("first_addr", IMEM_ADDR, 32'h100);
        chk_bubble("first");

        // Zero-wait streaming
        step();
        chk_valid("s100", 32'h100);
        chk("s100_addr", IMEM_ADDR, 32'h104);
        step();
        chk_valid("s104", 32'h104);
        step();
        chk_valid("s108", 32'h108);
        chk("s108_addr", IMEM_ADDR, 32'h10C);

        // Two wait cycles on 0x10C
        IMEM_BUSYWAIT = 1'b1;
        step();
        chk_bubble("w1");
        chk("w1_pc", IFID_PC, 32'h108);
        chk("w1_addr", IMEM_ADDR, 32'h10C);
        step();
        chk_bubble("w2");
        chk("w2_addr", IMEM_ADDR, 32'h10C);
        IMEM_BUSYWAIT = 1'b0;
        step();
        chk_valid("w_done", 32'h10C);
        chk("w_done_addr", IMEM_ADDR, 32'h110);

        // Three stall cycles: 0x110 re-read, IF/ID frozen
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_valid("stall_hold", 32'h10C);
            chk("stall_addr", IMEM_ADDR, 32'h110);
        end
        STALL = 1'b0;
        step();
        chk_valid("stall_rel", 32'h110);
        chk("stall_rel_addr", IMEM_ADDR, 32'h114);

        // Redirect while 0x114 is busy, then a second redirect in DISCARD
        IMEM_BUSYWAIT = 1'b1;
        step();
        chk_bubble("pre_flush");
        FLUSH         = 1'b1;
        BRANCH_TARGET = 32'h203;
        step();
        chk("disc1_addr", IMEM_ADDR, 32'h114);
        chk("disc1_read", {31'h0, IMEM_READ}, 32'h1);
        chk_bubble("disc1");
        BRANCH_TARGET = 32'h300;
        step();
        chk("disc2_addr", IMEM_ADDR, 32'h114);
        chk_bubble("disc2");
        FLUSH         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        step();
        chk("redir_addr", IMEM_ADDR, 32'h300);
        chk_bubble("redir");
        step();
        chk_valid("redir_tgt", 32'h300);
        chk("redir_next", IMEM_ADDR, 32'h304);

        // STALL and FLUSH together: flush wins
        STALL         = 1'b1;
        FLUSH         = 1'b1;
        BRANCH_TARGET = 32'h40;
        step();
        chk("sf_addr", IMEM_ADDR, 32'h40);
        chk("sf_pc", IFID_PC, 32'h300);
        chk_bubble("sf");
        STALL = 1'b0;
        FLUSH = 1'b0;
        step();
        chk_valid("sf_tgt", 32'h40);

        // Redirect to a misaligned top-of-memory target, then wrap
        FLUSH         = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFE;
        step();
        chk("wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        FLUSH = 1'b0;
        step();
        chk_valid("wrap_top", 32'hFFFF_FFFC);
        chk("wrap_next", IMEM_ADDR, 32'h0);
        step();
        chk_valid("wrap_zero", 32'h0);

        // Reset asserted mid busy read, checked before any further edge
        IMEM_BUSYWAIT = 1'b1;
        step();
        chk("busy_read", {31'h0, IMEM_READ}, 32'h1);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_read", {31'h0, IMEM_READ}, 32'h0);
        chk("arst_addr", IMEM_ADDR, 32'h100);
        chk("arst_pc", IFID_PC, 32'h0);
        chk_bubble("arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
